// File: rtl/spike_integrator.sv
// spike_integrator: buffers synapse spike events, accumulates their weights per timestep,
// and emits the summed current to the LIF neuron. Optional saturation: SPIKE_INT_SAT_EN.
module spike_integrator #(
    parameter int NUM_SYNAPSES = 256,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 8,
    localparam int AW          = $clog2(NUM_SYNAPSES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           spike_valid,
    input  logic [AW-1:0]                  spike_addr,
    output logic                           spike_ready,
    input  logic                           syn_stall,
    output logic [AW-1:0]                  syn_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] syn_weight,
    input  logic                           timestep,
    output logic                           current_valid,
    output logic signed [ACC_WIDTH-1:0]    current_out,
    output logic                           overflow,
    output logic                           busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    logic [1:0]                  state;
    logic [AW-1:0]               fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]               rd_ptr;
    logic [PW-1:0]               wr_ptr;
    logic [CW-1:0]               count;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic                        fifo_empty;
    logic                        push;
    logic                        pop;

    assign fifo_empty    = (count == '0);
    assign spike_ready   = (state == S_RUN) && (count < CW'(FIFO_DEPTH));
    assign push          = spike_valid && spike_ready;
    assign pop           = ((state == S_RUN) || (state == S_DRAIN)) && !fifo_empty && !syn_stall;
    assign syn_addr      = fifo_empty ? '0 : fifo_mem[rd_ptr];
    assign current_valid = (state == S_EMIT);
    assign current_out   = current_valid ? acc : '0;
    assign busy          = (state != S_RUN);

    // Storage needs no reset: pointers and count alone define the valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= spike_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SPIKE_INT_SAT_EN
    logic signed [ACC_WIDTH:0] w_ext;
    logic signed [ACC_WIDTH:0] sum_wide;
    logic                      clamp;
    logic                      ovf_q;

    // One guard bit: disagreement between the top two bits means the sum left range.
    always_comb begin
        w_ext    = {{(ACC_WIDTH + 1 - WEIGHT_WIDTH){syn_weight[WEIGHT_WIDTH-1]}}, syn_weight};
        sum_wide = {acc[ACC_WIDTH-1], acc} + w_ext;
        clamp    = (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]);
        if (!clamp) begin
            acc_next = sum_wide[ACC_WIDTH-1:0];
        end else if (sum_wide[ACC_WIDTH]) begin
            acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == S_EMIT) begin
            ovf_q <= 1'b0;
        end else if (pop && clamp) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    logic signed [ACC_WIDTH-1:0] w_ext;

    always_comb begin
        w_ext    = {{(ACC_WIDTH - WEIGHT_WIDTH){syn_weight[WEIGHT_WIDTH-1]}}, syn_weight};
        acc_next = acc + w_ext;
    end

    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            acc   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (pop)      acc   <= acc_next;
                    if (timestep) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop)        acc   <= acc_next;
                    if (fifo_empty) state <= S_EMIT;
                end
                S_EMIT: begin
                    acc   <= '0;
                    state <= S_RUN;
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_integrator.sv
// Directed self-checking bench for spike_integrator: vector table of spike bursts
// plus hand sequences for saturation, stall backpressure, drain, same-cycle tick and reset.
module tb_spike_integrator;

    localparam int AW   = 8;
    localparam int WW   = 8;
    localparam int ACCW = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   spike_valid;
    logic [AW-1:0]          spike_addr;
    logic                   spike_ready;
    logic                   syn_stall;
    logic [AW-1:0]          syn_addr;
    logic signed [WW-1:0]   syn_weight;
    logic                   timestep;
    logic                   current_valid;
    logic signed [ACCW-1:0] current_out;
    logic                   overflow;
    logic                   busy;

    logic signed [WW-1:0] mem [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign syn_weight = mem[syn_addr];

    spike_integrator #(
        .NUM_SYNAPSES(256),
        .WEIGHT_WIDTH(WW),
        .ACC_WIDTH   (ACCW),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spike_valid  (spike_valid),
        .spike_addr   (spike_addr),
        .spike_ready  (spike_ready),
        .syn_stall    (syn_stall),
        .syn_addr     (syn_addr),
        .syn_weight   (syn_weight),
        .timestep     (timestep),
        .current_valid(current_valid),
        .current_out  (current_out),
        .overflow     (overflow),
        .busy         (busy)
    );

    typedef struct {
        int               n;
        logic [3:0][7:0]  a;
        int               exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for the emit pulse and checks it lasts one cycle.
    task automatic wait_valid(output int val, output int lat, output int ov);
        lat = 0;
        while (!current_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        val = current_valid ? int'(current_out) : 32'h7fff_ffff;
        ov  = int'(overflow);
        @(negedge clk);
        check("valid_one_cycle", int'(current_valid), 0);
        check("out_zero_idle", int'(current_out), 0);
    endtask

    task automatic tick_collect(output int val, output int lat, output int ov);
        @(negedge clk);
        spike_valid = 1'b0;
        timestep    = 1'b1;
        @(negedge clk);
        timestep = 1'b0;
        wait_valid(val, lat, ov);
    endtask

    initial begin
        int val, lat, ov, cnt, extra, bad;
        logic [7:0] stall_list [9];

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[1]  = 8'sd127;
        mem[3]  = 8'sd5;
        mem[7]  = -8'sd2;
        mem[10] = -8'sd128;
        mem[20] = 8'sd100;

        vecs[0] = '{n: 3, a: {8'd0, 8'd3, 8'd7, 8'd3},   exp: 8};
        vecs[1] = '{n: 0, a: {8'd0, 8'd0, 8'd0, 8'd0},   exp: 0};
        vecs[2] = '{n: 2, a: {8'd0, 8'd0, 8'd10, 8'd10}, exp: -256};
        vecs[3] = '{n: 4, a: {8'd3, 8'd1, 8'd7, 8'd20},  exp: 230};
        vecs[4] = '{n: 1, a: {8'd0, 8'd0, 8'd0, 8'd7},   exp: -2};

        stall_list = '{8'd3, 8'd7, 8'd20, 8'd10, 8'd3, 8'd7, 8'd1, 8'd20, 8'd3};

        rst_n       = 1'b0;
        spike_valid = 1'b0;
        spike_addr  = '0;
        syn_stall   = 1'b0;
        timestep    = 1'b0;
        #12;
        check("rst_valid", int'(current_valid), 0);
        check("rst_out", int'(current_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(spike_ready), 1);
        check("rst_syn_addr", int'(syn_addr), 0);
        check("rst_overflow", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: spikes on consecutive cycles, then a tick.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                @(negedge clk);
                spike_valid = 1'b1;
                spike_addr  = vecs[v].a[i];
            end
            tick_collect(val, lat, ov);
            check($sformatf("vec%0d_current", v), val, vecs[v].exp);
            check($sformatf("vec%0d_latency", v), lat, 1);
            check($sformatf("vec%0d_overflow", v), ov, 0);
        end

        // 300 x 127 overruns a 16-bit accumulator.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            spike_valid = 1'b1;
            spike_addr  = 8'd1;
        end
        tick_collect(val, lat, ov);
`ifdef SPIKE_INT_SAT_EN
        check("sat_current", val, 32767);
        check("sat_overflow", ov, 1);
`else
        check("wrap_current", val, -27436);
        check("wrap_overflow", ov, 0);
`endif
        check("ovf_cleared", int'(overflow), 0);

        // Backpressure: stall fills the FIFO, release drains it in order.
        @(negedge clk);
        syn_stall = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            spike_valid = 1'b1;
            spike_addr  = stall_list[cnt];
            @(posedge clk);
            if (spike_ready) cnt++;
            @(negedge clk);
        end
        check("stall_accepts", cnt, 8);
        check("stall_ready_low", int'(spike_ready), 0);
        syn_stall = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("stall_head%0d", k), int'(syn_addr), int'(stall_list[k]));
            if (k == 0) check("full_ready_low", int'(spike_ready), 0);
            if (k == 1) check("ninth_ready", int'(spike_ready), 1);
            if (k == 2) spike_valid = 1'b0;
            @(negedge clk);
        end
        check("stall_drained_addr", int'(syn_addr), 0);
        tick_collect(val, lat, ov);
        check("stall_current", val, 210);

        // Tick with 4 queued entries held by stall; second tick during drain.
        @(negedge clk);
        syn_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            spike_valid = 1'b1;
            spike_addr  = 8'd3;
            @(negedge clk);
        end
        spike_valid = 1'b0;
        timestep    = 1'b1;
        @(negedge clk);
        timestep  = 1'b0;
        syn_stall = 1'b0;
        lat = 0;
        bad = 0;
        while (!current_valid && lat < 50) begin
            if (!busy || spike_ready) bad++;
            if (lat == 1) timestep = 1'b1;
            if (lat == 2) timestep = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("drain_busy_not_ready", bad, 0);
        check("drain_latency", lat, 5);
        check("drain_current", int'(current_out), 20);
        check("emit_busy", int'(busy), 1);
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (current_valid) extra++;
        end
        check("no_extra_valid", extra, 0);
        check("idle_busy", int'(busy), 0);

        // Spike accepted on the tick edge belongs to the ending timestep.
        @(negedge clk);
        spike_valid = 1'b1;
        spike_addr  = 8'd3;
        @(negedge clk);
        spike_addr = 8'd7;
        timestep   = 1'b1;
        @(negedge clk);
        spike_valid = 1'b0;
        timestep    = 1'b0;
        wait_valid(val, lat, ov);
        check("same_cycle_current", val, 3);
        tick_collect(val, lat, ov);
        check("same_cycle_next", val, 0);

        // Reset during DRAIN with 3 entries queued and a partial sum present.
        @(negedge clk);
        spike_valid = 1'b1;
        spike_addr  = 8'd3;
        @(negedge clk);
        spike_valid = 1'b0;
        @(negedge clk);
        syn_stall   = 1'b1;
        spike_valid = 1'b1;
        spike_addr  = 8'd3;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        spike_valid = 1'b0;
        timestep    = 1'b1;
        @(negedge clk);
        timestep = 1'b0;
        check("pre_rst_busy", int'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(spike_ready), 1);
        check("mid_rst_syn_addr", int'(syn_addr), 0);
        check("mid_rst_valid", int'(current_valid), 0);
        check("mid_rst_out", int'(current_out), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        syn_stall = 1'b0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (current_valid) extra++;
        end
        check("post_rst_no_valid", extra, 0);
        @(negedge clk);
        spike_valid = 1'b1;
        spike_addr  = 8'd7;
        tick_collect(val, lat, ov);
        check("post_rst_current", val, -2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
